// File: rtl/touch_adc_pkg.sv
// touch_adc_pkg: shared types and constants for the ADS7843-style touch
// responder.
//   state_t        responder frame FSM states
//   X/Y_CHAN_DEF   default A2..A0 codes selecting the X and Y measurements
//   DATA_BITS_*    reply lengths for 12-bit and 8-bit conversion modes
//   FLD_*          bit positions inside the stored control word
//                  {A2,A1,A0,MODE,PD1,PD0}; SER/DFR is not stored
package touch_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CTRL,
    BUSYW,
    BUSY,
    DATA
  } state_t;

  localparam logic [2:0] X_CHAN_DEF = 3'b101;
  localparam logic [2:0] Y_CHAN_DEF = 3'b001;

  localparam int unsigned DATA_BITS_12 = 12;
  localparam int unsigned DATA_BITS_8  = 8;

  // Control bits following the start bit: A2,A1,A0,MODE,SER,PD1,PD0.
  localparam int unsigned CTRL_BITS = 7;
  // Position (0-based, after the start bit) at which SER/DFR arrives.
  localparam int unsigned SER_INDEX = 4;

  localparam int unsigned FLD_A_MSB = 5;
  localparam int unsigned FLD_A_LSB = 3;
  localparam int unsigned FLD_MODE  = 2;
  localparam int unsigned FLD_PD1   = 1;
  localparam int unsigned FLD_PD0   = 0;

endpackage

// File: rtl/touch_adc_responder_spi_in_sync.sv
// spi_in_sync: brings the asynchronous SPI pins into the clk domain.
//   clk, reset     system clock, synchronous active-high reset
//   sclk           SPI clock pin   -> sclk_rise / sclk_fall single-cycle pulses
//   ss_n           chip select pin -> ss_n_sync (resets to deselected)
//   mosi           data pin        -> mosi_sync, aligned with the sclk pulses
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_n_sync,
  output logic mosi_sync
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ss_n_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q    <= '0;
      ss_n_q    <= '1;
      mosi_q    <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ss_n_q    <= {ss_n_q[SYNC_STAGES-2:0], ss_n};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_q[SYNC_STAGES-1];
    end
  end

  // mosi runs through the same depth as sclk, so the value seen with a rise
  // pulse is the pin value at that SCLK edge.
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_prev;
  assign ss_n_sync = ss_n_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/touch_adc_responder.sv
// touch_adc_responder: device end of an ADS7843-compatible touch SPI link.
//   clk_clk, reset_reset   system clock (>= 8x SCLK), sync active-high reset
//   spi_sclk/ss_n/mosi     SPI mode 0 from the master, asynchronous
//   spi_miso, spi_miso_oe  reply data and its output enable
//   busy, penirq_n         conversion busy and pen interrupt, as the real part
//   pos_x, pos_y, pen_down position source from fabric
//   frame_done             one-cycle pulse once a reply has been shifted out
module touch_adc_responder
  import touch_adc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [2:0]  X_CHAN      = X_CHAN_DEF,
  parameter logic [2:0]  Y_CHAN      = Y_CHAN_DEF
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        busy,
  output logic        penirq_n,
  input  logic [11:0] pos_x,
  input  logic [11:0] pos_y,
  input  logic        pen_down,
  output logic        frame_done
);

  logic sclk_rise;
  logic sclk_fall;
  logic ss_n_s;
  logic mosi_s;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk_clk),
    .reset     (reset_reset),
    .sclk      (spi_sclk),
    .ss_n      (spi_ss_n),
    .mosi      (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_n_sync (ss_n_s),
    .mosi_sync (mosi_s)
  );

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [11:0] data_q, data_d;
  logic        mode8_q, mode8_d;
  logic [1:0]  pd_q, pd_d;
  logic        busy_q, busy_d;
  logic        miso_q, miso_d;
  logic        done_q, done_d;
  logic        oe_q;
  logic        penirq_q;

  logic [5:0]  kept;
  logic [2:0]  chan;
  logic [11:0] sel;
  logic [3:0]  nbits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    mode8_d = mode8_q;
    pd_d    = pd_q;
    busy_d  = busy_q;
    miso_d  = miso_q;
    done_d  = 1'b0;

    // Completed control word as it stands on the final (PD0) rise.
    kept  = {ctrl_q, mosi_s};
    chan  = kept[FLD_A_MSB:FLD_A_LSB];
    sel   = '0;
    nbits = mode8_q ? 4'(DATA_BITS_8) : 4'(DATA_BITS_12);

    if (ss_n_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (sclk_rise && mosi_s) begin
            state_d = CTRL;
            cnt_d   = '0;
          end
        end
        CTRL: begin
          if (sclk_rise) begin
            // SER/DFR is clocked past but not stored.
            if (cnt_q != 4'(SER_INDEX)) ctrl_d = {ctrl_q[3:0], mosi_s};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(CTRL_BITS - 1)) begin
              if (chan == X_CHAN)      sel = pos_x;
              else if (chan == Y_CHAN) sel = pos_y;
              if (kept[FLD_MODE]) sel[3:0] = '0;
              data_d  = sel;
              mode8_d = kept[FLD_MODE];
              pd_d    = {kept[FLD_PD1], kept[FLD_PD0]};
              state_d = BUSYW;
            end
          end
        end
        BUSYW: begin
          if (sclk_fall) begin
            busy_d  = 1'b1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (sclk_fall) begin
            busy_d  = 1'b0;
            miso_d  = data_q[11];
            data_d  = {data_q[10:0], 1'b0};
            cnt_d   = 4'd1;
            state_d = DATA;
          end
        end
        DATA: begin
          if (sclk_fall) begin
            if (cnt_q == nbits) begin
              miso_d  = 1'b0;
              done_d  = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              miso_d = data_q[11];
              data_d = {data_q[10:0], 1'b0};
              cnt_d  = cnt_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ctrl_q   <= '0;
      data_q   <= '0;
      mode8_q  <= 1'b0;
      pd_q     <= '0;
      busy_q   <= 1'b0;
      miso_q   <= 1'b0;
      done_q   <= 1'b0;
      oe_q     <= 1'b0;
      penirq_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      mode8_q  <= mode8_d;
      pd_q     <= pd_d;
      busy_q   <= busy_d;
      miso_q   <= miso_d;
      done_q   <= done_d;
      oe_q     <= ~ss_n_s;
      penirq_q <= ~(pen_down & ~pd_q[0] & (state_q == IDLE || state_q == CTRL));
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign busy        = busy_q;
  assign penirq_n    = penirq_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_touch_adc_responder.sv
module tb_touch_adc_responder;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        spi_sclk, spi_ss_n, spi_mosi;
  logic        spi_miso, spi_miso_oe, busy, penirq_n, frame_done;
  logic [11:0] pos_x, pos_y;
  logic        pen_down;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rx_bits;
  logic [1:0]  pd_model;

  touch_adc_responder #(
    .SYNC_STAGES(2),
    .X_CHAN     (3'b101),
    .Y_CHAN     (3'b001)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .spi_sclk   (spi_sclk),
    .spi_ss_n   (spi_ss_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .busy       (busy),
    .penirq_n   (penirq_n),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pen_down   (pen_down),
    .frame_done (frame_done)
  );

  always #10 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: reply value the ADS7843 gives for a control byte.
  function automatic logic [11:0] model_val(input logic [7:0] cb, input logic [11:0] px,
                                            input logic [11:0] py);
    logic [11:0] v;
    case (cb[6:4])
      3'b101:  v = px;
      3'b001:  v = py;
      default: v = 12'h000;
    endcase
    return cb[3] ? (v >> 4) : v;
  endfunction

  // Monitor: each frame_done pulse is compared against the oldest expectation.
  always @(negedge clk_clk) begin
    if (frame_done) begin
      fd_count++;
      check("reply_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("reply", rx_bits, exp_q.pop_front());
    end
  end

  // Master: clocks nr SCLK cycles with cb in the first 8; rst_at >= 0 asserts
  // reset while SCLK is low before that cycle.
  task automatic do_frame(input logic [7:0] cb, input int nr, input bit chg,
                          input logic [11:0] nx, input logic [11:0] ny, input int rst_at);
    int n;
    int fd0;
    bit rst_done;
    logic [11:0] val;
    logic pd_old;
    logic [31:0] busy_w, pen_w, oe_w, e_miso, e_busy, e_pen, e_oe;
    n = cb[3] ? 8 : 12;
    val = model_val(cb, pos_x, pos_y);
    pd_old = pd_model[0];
    rst_done = 1'b0;
    if (nr >= 9 + n && rst_at < 0) exp_q.push_back(32'(val));
    fd0 = fd_count;
    rx_bits = '0; busy_w = '0; pen_w = '0; oe_w = '0;
    e_miso = '0; e_busy = '0; e_pen = '0; e_oe = '0;
    spi_ss_n = 1'b0;
    #300;
    for (int r = 0; r < nr; r++) begin
      if (r == rst_at) begin
        @(negedge clk_clk) reset_reset = 1'b1;
        @(posedge clk_clk);
        #1;
        check("reset_mid_frame", {27'd0, spi_miso, spi_miso_oe, busy, penirq_n, frame_done},
              32'b00010);
        @(negedge clk_clk) reset_reset = 1'b0;
        pd_model = 2'b00;
        rst_done = 1'b1;
        break;
      end
      if (chg && r == 12) begin
        pos_x = nx;
        pos_y = ny;
      end
      spi_mosi = (r < 8) ? cb[7-r] : 1'b0;
      #250;
      rx_bits = {rx_bits[30:0], spi_miso};
      busy_w  = {busy_w[30:0], busy};
      pen_w   = {pen_w[30:0], penirq_n};
      oe_w    = {oe_w[30:0], spi_miso_oe};
      e_miso  = {e_miso[30:0], (r >= 9 && r < 9 + n) ? val[n-1-(r-9)] : 1'b0};
      e_busy  = {e_busy[30:0], r == 8};
      e_pen   = {e_pen[30:0], (r < 8) ? ~(pen_down & ~pd_old) :
                              (r <= 8 + n) ? 1'b1 : ~(pen_down & ~cb[0])};
      e_oe    = {e_oe[30:0], 1'b1};
      if (r == 7) pd_model = cb[1:0];
      spi_sclk = 1'b1;
      #250;
      spi_sclk = 1'b0;
    end
    if (!rst_done) begin
      check("miso_bits", rx_bits, e_miso);
      check("busy_bits", busy_w, e_busy);
      check("penirq_bits", pen_w, e_pen);
      check("oe_bits", oe_w, e_oe);
      check("frame_done_count", 32'(fd_count - fd0), (nr >= 9 + n) ? 32'd1 : 32'd0);
    end
    #250;
    spi_mosi = 1'b0;
    spi_ss_n = 1'b1;
    repeat (4) @(posedge clk_clk);
    #1;
    check("deselect_oe_busy", {30'd0, spi_miso_oe, busy}, 32'd0);
    #1000;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cb;
    reset_reset = 1'b1;
    spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    pos_x = '0; pos_y = '0; pen_down = 1'b0;
    pd_model = 2'b00;
    repeat (3) @(posedge clk_clk);
    #1;
    check("reset_vals", {27'd0, spi_miso, spi_miso_oe, busy, penirq_n, frame_done}, 32'b00010);
    @(negedge clk_clk) reset_reset = 1'b0;
    repeat (5) @(posedge clk_clk);

    pen_down = 1'b1;
    pos_x = 12'hA5C;
    do_frame(8'hD0, 24, 1'b0, 12'h0, 12'h0, -1);
    pos_y = 12'h3F7;
    do_frame(8'h98, 24, 1'b0, 12'h0, 12'h0, -1);
    pos_x = 12'h111;
    do_frame(8'hD0, 24, 1'b1, 12'hFFF, pos_y, -1);
    pos_x = 12'hA5C;
    do_frame(8'hD0, 14, 1'b0, 12'h0, 12'h0, -1);
    do_frame(8'hD0, 24, 1'b0, 12'h0, 12'h0, -1);
    do_frame(8'hD1, 24, 1'b0, 12'h0, 12'h0, -1);
    do_frame(8'hD1, 24, 1'b0, 12'h0, 12'h0, -1);
    pos_x = 12'h321;
    do_frame(8'hD1, 24, 1'b0, 12'h0, 12'h0, 13);
    pos_x = 12'h7E4;
    do_frame(8'h80, 24, 1'b0, 12'h0, 12'h0, -1);
    do_frame(8'hD0, 24, 1'b0, 12'h0, 12'h0, -1);

    for (int i = 0; i < 20; i++) begin
      cb = {1'b1, 7'($urandom)};
      if ($urandom_range(0, 2) != 0) cb[6:4] = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b001;
      pos_x = 12'($urandom);
      pos_y = 12'($urandom);
      pen_down = 1'($urandom);
      do_frame(cb, 24, 1'($urandom), 12'($urandom), 12'($urandom), -1);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
